// File: rtl/b1_scfifo_ctrl.sv
// Single-clock FIFO with inferred dual-port storage, occupancy FSM,
// programmable almost-full/almost-empty thresholds and overflow/underflow pulses.
module b1_scfifo_ctrl #(
  parameter int unsigned DWIDTH       = 8,
  parameter int unsigned AWIDTH       = 8,
  parameter int unsigned ALMOST_FULL  = (2**AWIDTH) - 2,
  parameter int unsigned ALMOST_EMPTY = 2
) (
  input  logic              clk_i,
  input  logic              srst_i,
  input  logic [DWIDTH-1:0] data_i,
  input  logic              wrreq_i,
  input  logic              rdreq_i,
  output logic [DWIDTH-1:0] q_o,
  output logic [AWIDTH:0]   usedw_o,
  output logic              empty_o,
  output logic              full_o,
  output logic              almost_full_o,
  output logic              almost_empty_o,
  output logic              overflow_o,
  output logic              underflow_o
);

  localparam int unsigned DEPTH = 2**AWIDTH;
  localparam int unsigned UW    = AWIDTH + 1;

  typedef enum logic [1:0] {ZERO_ST, NORM_ST, FULL_ST} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [DWIDTH-1:0]   r_mem [DEPTH];
  logic [AWIDTH-1:0]   r_wr_ptr;
  logic [AWIDTH-1:0]   r_rd_ptr;
  logic [DWIDTH-1:0]   r_q;
  logic [UW-1:0]       r_usedw;
  logic                r_empty;
  logic                r_full;
  logic                r_almost_full;
  logic                r_almost_empty;
  logic                r_overflow;
  logic                r_underflow;
  logic                w_wr_acc;
  logic                w_rd_acc;
  logic [UW-1:0]       w_usedw_nxt;

  // Acceptance depends only on the registered occupancy state
  assign w_wr_acc    = wrreq_i & (r_state != FULL_ST);
  assign w_rd_acc    = rdreq_i & (r_state != ZERO_ST);
  assign w_usedw_nxt = r_usedw + UW'(w_wr_acc) - UW'(w_rd_acc);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ZERO_ST: if (w_wr_acc) w_state_nxt = NORM_ST;
      NORM_ST: begin
        if ((r_usedw == UW'(1)) && w_rd_acc && !w_wr_acc)
          w_state_nxt = ZERO_ST;
        else if ((r_usedw == UW'(DEPTH - 1)) && w_wr_acc && !w_rd_acc)
          w_state_nxt = FULL_ST;
      end
      FULL_ST: if (w_rd_acc) w_state_nxt = NORM_ST;
      default: w_state_nxt = ZERO_ST;
    endcase
  end

  // Storage is not reset; a reset cycle must not write it
  always_ff @(posedge clk_i) begin
    if (w_wr_acc && !srst_i) r_mem[r_wr_ptr] <= data_i;
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      r_state        <= ZERO_ST;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_q            <= '0;
      r_usedw        <= '0;
      r_empty        <= 1'b1;
      r_full         <= 1'b0;
      r_almost_full  <= 1'b0;
      r_almost_empty <= 1'b1;
      r_overflow     <= 1'b0;
      r_underflow    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + AWIDTH'(1);
      if (w_rd_acc) begin
        r_rd_ptr <= r_rd_ptr + AWIDTH'(1);
        r_q      <= r_mem[r_rd_ptr];
      end
      // Flags come from the next count so they track usedw_o exactly
      r_usedw        <= w_usedw_nxt;
      r_empty        <= (w_usedw_nxt == '0);
      r_full         <= (w_usedw_nxt == UW'(DEPTH));
      r_almost_full  <= (w_usedw_nxt >= UW'(ALMOST_FULL));
      r_almost_empty <= (w_usedw_nxt <  UW'(ALMOST_EMPTY));
      r_overflow     <= wrreq_i & (r_state == FULL_ST);
      r_underflow    <= rdreq_i & (r_state == ZERO_ST);
    end
  end

  assign q_o            = r_q;
  assign usedw_o        = r_usedw;
  assign empty_o        = r_empty;
  assign full_o         = r_full;
  assign almost_full_o  = r_almost_full;
  assign almost_empty_o = r_almost_empty;
  assign overflow_o     = r_overflow;
  assign underflow_o    = r_underflow;

endmodule

// File: tb/tb_b1_scfifo_ctrl.sv
// Directed, table-driven bench for b1_scfifo_ctrl with DEPTH=4,
// ALMOST_FULL=3, ALMOST_EMPTY=1, plus a hand-written pointer-wrap sequence.
module tb_b1_scfifo_ctrl;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 2;
  localparam int unsigned NV = 30;

  logic          clk = 1'b0;
  logic          srst;
  logic [DW-1:0] data;
  logic          wrreq;
  logic          rdreq;
  logic [DW-1:0] q;
  logic [AW:0]   usedw;
  logic          empty, full, afull, aempty, ovf, unf;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic          srst;
    logic          wr;
    logic          rd;
    logic [7:0]    d;
    logic [2:0]    u;
    logic [7:0]    q;
    logic          ov;
    logic          un;
  } vec_t;

  vec_t vecs [NV];

  b1_scfifo_ctrl #(
    .DWIDTH(8), .AWIDTH(2), .ALMOST_FULL(3), .ALMOST_EMPTY(1)
  ) dut (
    .clk_i(clk), .srst_i(srst), .data_i(data), .wrreq_i(wrreq), .rdreq_i(rdreq),
    .q_o(q), .usedw_o(usedw), .empty_o(empty), .full_o(full),
    .almost_full_o(afull), .almost_empty_o(aempty),
    .overflow_o(ovf), .underflow_o(unf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s step %0d: got 0x%0h expected 0x%0h", nm, idx, act, exp);
    end
  endtask

  // Flags follow directly from the expected count for DEPTH=4, AF=3, AE=1
  task automatic chk_all(input int idx, input logic [2:0] eu, input logic [7:0] eq,
                         input logic eov, input logic eun);
    chk("usedw", idx, 32'(usedw), 32'(eu));
    chk("empty", idx, 32'(empty), 32'(eu == 3'd0));
    chk("full", idx, 32'(full), 32'(eu == 3'd4));
    chk("almost_full", idx, 32'(afull), 32'(eu >= 3'd3));
    chk("almost_empty", idx, 32'(aempty), 32'(eu < 3'd1));
    chk("q", idx, 32'(q), 32'(eq));
    chk("overflow", idx, 32'(ovf), 32'(eov));
    chk("underflow", idx, 32'(unf), 32'(eun));
  endtask

  task automatic step(input logic s, input logic w, input logic r, input logic [7:0] d);
    srst = s; wrreq = w; rdreq = r; data = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    //                srst  wr    rd    data   usedw  q      ov    un
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 8'h00, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b1, 1'b0, 8'hA1, 3'd1, 8'h00, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b0, 8'hA2, 3'd2, 8'h00, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 8'hA3, 3'd3, 8'h00, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 8'hA4, 3'd4, 8'h00, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b1, 1'b0, 8'hFF, 3'd4, 8'h00, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 8'h00, 3'd4, 8'h00, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 8'h00, 3'd3, 8'hA1, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 8'h00, 3'd2, 8'hA2, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 8'h00, 3'd1, 8'hA3, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 8'h00, 3'd0, 8'hA4, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 8'h00, 3'd0, 8'hA4, 1'b0, 1'b1};
    vecs[12] = '{1'b0, 1'b1, 1'b1, 8'h55, 3'd1, 8'hA4, 1'b0, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 8'h00, 3'd1, 8'hA4, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 1'b1, 8'h00, 3'd0, 8'h55, 1'b0, 1'b0};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 8'h01, 3'd1, 8'h55, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 1'b1, 1'b0, 8'h02, 3'd2, 8'h55, 1'b0, 1'b0};
    vecs[17] = '{1'b0, 1'b1, 1'b0, 8'h03, 3'd3, 8'h55, 1'b0, 1'b0};
    vecs[18] = '{1'b0, 1'b1, 1'b0, 8'h04, 3'd4, 8'h55, 1'b0, 1'b0};
    vecs[19] = '{1'b0, 1'b1, 1'b1, 8'h99, 3'd3, 8'h01, 1'b1, 1'b0};
    vecs[20] = '{1'b0, 1'b0, 1'b0, 8'h00, 3'd3, 8'h01, 1'b0, 1'b0};
    vecs[21] = '{1'b0, 1'b0, 1'b1, 8'h00, 3'd2, 8'h02, 1'b0, 1'b0};
    vecs[22] = '{1'b0, 1'b0, 1'b1, 8'h00, 3'd1, 8'h03, 1'b0, 1'b0};
    vecs[23] = '{1'b0, 1'b0, 1'b1, 8'h00, 3'd0, 8'h04, 1'b0, 1'b0};
    vecs[24] = '{1'b0, 1'b1, 1'b0, 8'h21, 3'd1, 8'h04, 1'b0, 1'b0};
    vecs[25] = '{1'b0, 1'b1, 1'b0, 8'h22, 3'd2, 8'h04, 1'b0, 1'b0};
    vecs[26] = '{1'b0, 1'b1, 1'b0, 8'h23, 3'd3, 8'h04, 1'b0, 1'b0};
    vecs[27] = '{1'b1, 1'b1, 1'b0, 8'h77, 3'd0, 8'h00, 1'b0, 1'b0};
    vecs[28] = '{1'b0, 1'b1, 1'b0, 8'h3C, 3'd1, 8'h00, 1'b0, 1'b0};
    vecs[29] = '{1'b0, 1'b0, 1'b1, 8'h00, 3'd0, 8'h3C, 1'b0, 1'b0};

    srst = 1'b1; wrreq = 1'b0; rdreq = 1'b0; data = '0;

    for (int i = 0; i < int'(NV); i++) begin
      step(vecs[i].srst, vecs[i].wr, vecs[i].rd, vecs[i].d);
      chk_all(i, vecs[i].u, vecs[i].q, vecs[i].ov, vecs[i].un);
    end

    // Pointer wrap: hold two words while streaming ten simultaneous write/reads
    step(1'b0, 1'b1, 1'b0, 8'h10);
    chk_all(100, 3'd1, 8'h3C, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'h11);
    chk_all(101, 3'd2, 8'h3C, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1, 1'b1, 8'(8'h12 + i));
      chk_all(102 + i, 3'd2, 8'(8'h10 + i), 1'b0, 1'b0);
    end
    step(1'b0, 1'b0, 1'b1, 8'h00);
    chk_all(112, 3'd1, 8'h1A, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'h00);
    chk_all(113, 3'd0, 8'h1B, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    chk_all(114, 3'd0, 8'h1B, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/b1_scfifo_ctrl.md
# b1_scfifo_ctrl

Parametrised single-clock FIFO with internal storage, a three-state occupancy FSM, programmable almost-full/almost-empty thresholds and overflow/underflow reporting. It sits between a producer and a consumer in the same clock domain and replaces the bare flag FSM with a complete buffer. Read data follows normal (non-show-ahead) timing. Storage is dual-port RAM inferred inside the block.

## Interface
- DWIDTH, 8: data word width.
- AWIDTH, 8: address width; depth DEPTH = 2**AWIDTH words.
- ALMOST_FULL, 2**AWIDTH-2: almost_full_o asserts when usedw_o >= ALMOST_FULL; legal range 1..DEPTH.
- ALMOST_EMPTY, 2: almost_empty_o asserts when usedw_o < ALMOST_EMPTY; legal range 1..DEPTH.

- clk_i  in  1  clock; all logic on rising edge.
- srst_i  in  1  reset, synchronous, active-high.
- data_i  in  DWIDTH  write data.
- wrreq_i  in  1  write request.
- rdreq_i  in  1  read request.
- q_o  out  DWIDTH  read data, registered.
- usedw_o  out  AWIDTH+1  stored word count, 0..DEPTH.
- empty_o  out  1  usedw_o == 0.
- full_o  out  1  usedw_o == DEPTH.
- almost_full_o  out  1  usedw_o >= ALMOST_FULL.
- almost_empty_o  out  1  usedw_o < ALMOST_EMPTY.
- overflow_o  out  1  one-cycle pulse: write rejected.
- underflow_o  out  1  one-cycle pulse: read rejected.

## Operation
- FSM states: ZERO_ST (usedw 0), NORM_ST (1..DEPTH-1), FULL_ST (DEPTH).
- ZERO_ST -> NORM_ST on an accepted write.
- NORM_ST -> ZERO_ST when usedw == 1, the read is accepted and there is no accepted write.
- NORM_ST -> FULL_ST when usedw == DEPTH-1, the write is accepted and there is no accepted read.
- FULL_ST -> NORM_ST on an accepted read.
- Otherwise hold the current state.
- Acceptance is based on registered state only:
  - wr_acc = wrreq_i & !full_o.
  - rd_acc = rdreq_i & !empty_o.
- Simultaneous requests in NORM_ST: both are accepted; usedw is unchanged.
- Simultaneous requests while empty: the write is accepted, the read is rejected, and underflow_o pulses.
- Simultaneous requests while full: the read is accepted, the write is rejected, and overflow_o pulses.
- Write pointer and read pointer are AWIDTH bits each.
- Each pointer increments on its accepted operation and wraps DEPTH-1 -> 0 naturally.
- Pointers never index out of range.
- On wr_acc, data_i is written to mem[wr_ptr].
- On rd_acc, mem[rd_ptr] is registered into q_o.
- usedw_o(next) = usedw_o + wr_acc - rd_acc.
  - Width AWIDTH+1, so the value DEPTH is representable.
  - No wrap is possible, because of the acceptance rules.
- All flags are registered and computed from next usedw, so each flag is consistent with usedw_o in the same cycle.
- overflow_o and underflow_o are registered one-cycle pulses.
  - They are asserted the cycle after the rejected request.
  - They are not sticky.
- Reset values:
  - usedw_o = 0, empty_o = 1, full_o = 0, almost_full_o = 0.
  - almost_empty_o = 1.
  - overflow_o = 0, underflow_o = 0, q_o = 0.
  - Pointers = 0, state = ZERO_ST.
- Reset mid-operation: all of the above apply at the next edge and any in-flight request is discarded. RAM contents are not cleared, but they are unreachable until rewritten.

## Timing
- Write-to-flag latency: 1 cycle. An accepted write at edge N gives empty_o = 0 after edge N.
- Read latency: 1 cycle. With rdreq_i high in cycle N (accepted), q_o holds the word after edge N and keeps it until the next accepted read.
- First-word fall-through is not supported. A word written at edge N can be read by a rdreq_i in cycle N+1, with q_o valid after edge N+1.
- A rejected request has no effect on the pointers, usedw_o, q_o or RAM.
- srst_i takes priority over wrreq_i and rdreq_i in the same cycle.

## Test plan
All scenarios use DWIDTH=8, AWIDTH=2 (DEPTH=4), ALMOST_FULL=3, ALMOST_EMPTY=1.
- Reset and fill, then drain:
  - Stimulus: reset, write 0xA1..0xA4 on consecutive cycles.
  - After each write, usedw_o = 1, 2, 3, 4.
  - almost_empty_o drops after the first write; almost_full_o rises at usedw 3; full_o rises at usedw 4.
  - Read 4 times: q_o = 0xA1..0xA4 in order, each valid one cycle after its rdreq_i; empty_o = 1 at the end.
- Overflow:
  - Stimulus: fill to 4, then wrreq_i=1 with data 0xFF.
  - overflow_o pulses for exactly 1 cycle, usedw_o stays 4, and a later drain never returns 0xFF.
- Underflow and simultaneous request on empty:
  - Stimulus: from empty, wrreq_i=1 and rdreq_i=1 with data 0x55.
  - underflow_o pulses, usedw_o = 1, q_o unchanged.
  - The next read returns 0x55.
- Simultaneous request on full:
  - Stimulus: full with 0x01..0x04, then wrreq_i=1 and rdreq_i=1 with data 0x99.
  - q_o = 0x01, usedw_o = 3, overflow_o pulses.
- Wrap-around:
  - Stimulus: 10 cycles of simultaneous write/read of an incrementing pattern, with the FIFO holding 2 words.
  - usedw_o constant at 2, data order preserved across pointer wrap, no error pulses.
- Reset mid-operation:
  - Stimulus: at usedw 3, assert srst_i together with wrreq_i.
  - Next cycle: usedw_o = 0, empty_o = 1, almost_empty_o = 1, q_o = 0.
  - A subsequent write/read of 0x3C returns 0x3C.
